alu_decode_stage: RTL and testbench

//  Registered RV32I decode stage that produces the ALU control word and operand

---
 rtl/alu_decode_stage.sv | 231 +++++++++++++++++++++++
 tb/tb_alu_decode_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// RV32I decode stage: opcode/funct3/funct7 -> ALU select, immediate and operand selects,
// held in a single valid/ready pipeline register with flush and synchronous reset.
`timescale 1ns/1ps
module alu_decode_stage #(
  parameter bit ILLEGAL_DROP = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  alu_sel,
  output logic [31:0] imm,
  output logic        use_imm,
  output logic        use_pc,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [31:0] pc_out,
  output logic        illegal_o
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;

  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluXor  = 4'b1100;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluSltu = 4'b1111;
  localparam logic [3:0] AluSll  = 4'b1101;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1011;
  localparam logic [3:0] AluPassB = 4'b1010;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        f7_std, f7_alt, arith_alt;
  logic [3:0]  arith_alu;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_alu;
  logic [31:0] dec_imm;
  logic        dec_use_imm, dec_use_pc, dec_rw, dec_ill;
  logic        accept;

  logic        valid_d, valid_q, illegal_d, illegal_q;
  logic        use_imm_d, use_imm_q, use_pc_d, use_pc_q, rw_d, rw_q;
  logic [3:0]  alu_d, alu_q;
  logic [31:0] imm_d, imm_q, pc_d, pc_q;
  logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign f7_std = (funct7 == 7'b0000000);
  assign f7_alt = (funct7 == 7'b0100000);

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // OP-IMM has no subtract, so instr[30] only selects sra there.
  assign arith_alt = instr[30] & ((opcode == OpcOp) | (funct3 == 3'b101));

  always_comb begin
    arith_alu = AluAdd;
    case (funct3)
      3'b000:  arith_alu = arith_alt ? AluSub : AluAdd;
      3'b001:  arith_alu = AluSll;
      3'b010:  arith_alu = AluSlt;
      3'b011:  arith_alu = AluSltu;
      3'b100:  arith_alu = AluXor;
      3'b101:  arith_alu = arith_alt ? AluSra : AluSrl;
      3'b110:  arith_alu = AluOr;
      default: arith_alu = AluAnd;
    endcase
  end

  always_comb begin
    dec_alu     = AluAdd;
    dec_imm     = 32'h0;
    dec_use_imm = 1'b1;
    dec_use_pc  = 1'b0;
    dec_rw      = 1'b1;
    dec_ill     = 1'b0;
    case (opcode)
      OpcOp: begin
        dec_alu     = arith_alu;
        dec_use_imm = 1'b0;
        dec_ill     = !(f7_std || (f7_alt && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OpcOpImm: begin
        dec_alu = arith_alu;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm = {27'b0, instr[24:20]};
          dec_ill = !(f7_std || (f7_alt && funct3 == 3'b101));
        end else begin
          dec_imm = imm_i;
        end
      end
      OpcLui: begin
        dec_alu = AluPassB;
        dec_imm = imm_u;
      end
      OpcAuipc: begin
        dec_imm    = imm_u;
        dec_use_pc = 1'b1;
      end
      OpcLoad:  dec_imm = imm_i;
      OpcStore: begin
        dec_imm = imm_s;
        dec_rw  = 1'b0;
      end
      OpcBranch: begin
        dec_imm     = imm_b;
        dec_use_imm = 1'b0;
        dec_rw      = 1'b0;
        case (funct3)
          3'b000, 3'b001: dec_alu = AluSub;
          3'b100, 3'b101: dec_alu = AluSlt;
          3'b110, 3'b111: dec_alu = AluSltu;
          default:        dec_ill = 1'b1;
        endcase
      end
      OpcJal: begin
        dec_imm    = imm_j;
        dec_use_pc = 1'b1;
      end
      OpcJalr: dec_imm = imm_i;
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      dec_alu     = AluAdd;
      dec_imm     = 32'h0;
      dec_use_imm = 1'b0;
      dec_use_pc  = 1'b0;
      dec_rw      = 1'b0;
    end
    if (instr[11:7] == 5'd0) dec_rw = 1'b0;
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    alu_d     = alu_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    use_pc_d  = use_pc_q;
    rw_d      = rw_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    pc_d      = pc_q;
    illegal_d = accept && dec_ill;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = !(ILLEGAL_DROP && dec_ill);
    else if (out_ready) valid_d = 1'b0;
    else                valid_d = valid_q;
    if (accept) begin
      alu_d     = dec_alu;
      imm_d     = dec_imm;
      use_imm_d = dec_use_imm;
      use_pc_d  = dec_use_pc;
      rw_d      = dec_rw;
      rs1_d     = instr[19:15];
      rs2_d     = instr[24:20];
      rd_d      = instr[11:7];
      pc_d      = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      alu_q     <= 4'b0;
      imm_q     <= 32'h0;
      use_imm_q <= 1'b0;
      use_pc_q  <= 1'b0;
      rw_q      <= 1'b0;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      pc_q      <= 32'h0;
    end else begin
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
      alu_q     <= alu_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      use_pc_q  <= use_pc_d;
      rw_q      <= rw_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      pc_q      <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign illegal_o = illegal_q;
  assign alu_sel   = alu_q;
  assign imm       = imm_q;
  assign use_imm   = use_imm_q;
  assign use_pc    = use_pc_q;
  assign reg_write = rw_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign pc_out    = pc_q;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed cases plus random traffic through a queue-based
// scoreboard, run against both ILLEGAL_DROP settings side by side.
`timescale 1ns/1ps
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] instr, pc;
  int          n_chk = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic [31:0] imm;
    bit          use_imm, use_pc, rw, ill;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU code for the register/immediate arithmetic group by mnemonic.
  function automatic logic [3:0] arith(input logic [2:0] f3, input bit alt);
    case (f3)
      3'd0: return alt ? 4'b0110 : 4'b0010;
      3'd1: return 4'b1101;
      3'd2: return 4'b0111;
      3'd3: return 4'b1111;
      3'd4: return 4'b1100;
      3'd5: return alt ? 4'b1011 : 4'b1001;
      3'd6: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] p);
    exp_t        e;
    logic [31:0] iimm, simm, bimm, jimm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3   = i[14:12];
    f7   = i[31:25];
    iimm = 32'($signed(i) >>> 20);
    simm = (iimm & ~32'h1F) | ((i >> 7) & 32'h1F);
    bimm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
    jimm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    e.alu = 4'b0010; e.imm = 32'h0; e.use_imm = 1'b1; e.use_pc = 1'b0;
    e.rw = 1'b1; e.ill = 1'b0;
    e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7]; e.pc = p;
    case (i[6:0])
      7'h33: begin
        e.alu = arith(f3, f7 == 7'h20);
        e.use_imm = 1'b0;
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'h13: begin
        e.alu = arith(f3, f3 == 3'd5 && f7 == 7'h20);
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.imm = (i >> 20) & 32'h1F;
          e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
        end else e.imm = iimm;
      end
      7'h37: begin e.alu = 4'b1010; e.imm = i & 32'hFFFFF000; end
      7'h17: begin e.imm = i & 32'hFFFFF000; e.use_pc = 1'b1; end
      7'h03: e.imm = iimm;
      7'h23: begin e.imm = simm; e.rw = 1'b0; end
      7'h63: begin
        e.imm = bimm; e.use_imm = 1'b0; e.rw = 1'b0;
        if (f3 == 3'd0 || f3 == 3'd1) e.alu = 4'b0110;
        else if (f3 == 3'd4 || f3 == 3'd5) e.alu = 4'b0111;
        else if (f3 == 3'd6 || f3 == 3'd7) e.alu = 4'b1111;
        else e.ill = 1'b1;
      end
      7'h6F: begin e.imm = jimm; e.use_pc = 1'b1; end
      7'h67: e.imm = iimm;
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.alu = 4'b0010; e.rw = 1'b0; e.use_imm = 1'b0; end
    if (e.rd == 5'd0) e.rw = 1'b0;
    return e;
  endfunction

  function automatic bit ref_ill(input logic [31:0] i);
    exp_t t;
    t = ref_decode(i, 32'h0);
    return t.ill;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int          r;
    i = $urandom;
    case ($urandom_range(9))
      0: i[6:0] = 7'h33;
      1: i[6:0] = 7'h13;
      2: i[6:0] = 7'h37;
      3: i[6:0] = 7'h17;
      4: i[6:0] = 7'h03;
      5: i[6:0] = 7'h23;
      6: i[6:0] = 7'h63;
      7: i[6:0] = 7'h6F;
      8: i[6:0] = 7'h67;
      default: ;
    endcase
    r = $urandom_range(3);
    if (r < 2) i[31:25] = 7'h00;
    else if (r == 2) i[31:25] = 7'h20;
    return i;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        in_ready, out_valid, use_imm, use_pc, reg_write, illegal_o;
    logic [3:0]  alu_sel;
    logic [31:0] imm, pc_out;
    logic [4:0]  rs1, rs2, rd;
    exp_t        q[$];
    bit          exp_ill = 1'b0;

    alu_decode_stage #(.ILLEGAL_DROP(g == 1)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .pc        (pc),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .alu_sel   (alu_sel),
      .imm       (imm),
      .use_imm   (use_imm),
      .use_pc    (use_pc),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .reg_write (reg_write),
      .pc_out    (pc_out),
      .illegal_o (illegal_o)
    );

    // Stimulus side: a one-deep stage accepts only when empty after the consumer pop.
    always @(posedge clk) begin
      if (reset) begin
        q.delete();
        exp_ill <= 1'b0;
      end else begin
        if (flush) q.delete();
        exp_ill <= in_valid && !flush && q.size() == 0 && ref_ill(instr);
        if (in_valid && !flush && q.size() == 0 && !(g == 1 && ref_ill(instr)))
          q.push_back(ref_decode(instr, pc));
      end
    end

    always @(negedge clk) begin
      if (mon_en) begin
        chk($sformatf("in_ready[%0d]", g), 32'(in_ready), 32'(q.size() == 0 || out_ready));
        chk($sformatf("out_valid[%0d]", g), 32'(out_valid), 32'(q.size() != 0));
        chk($sformatf("illegal_o[%0d]", g), 32'(illegal_o), 32'(exp_ill));
        if (out_valid && q.size() != 0) begin
          chk($sformatf("alu_sel[%0d]", g), 32'(alu_sel), 32'(q[0].alu));
          chk($sformatf("use_imm[%0d]", g), 32'(use_imm), 32'(q[0].use_imm));
          chk($sformatf("reg_write[%0d]", g), 32'(reg_write), 32'(q[0].rw));
          chk($sformatf("rs1[%0d]", g), 32'(rs1), 32'(q[0].rs1));
          chk($sformatf("rs2[%0d]", g), 32'(rs2), 32'(q[0].rs2));
          chk($sformatf("rd[%0d]", g), 32'(rd), 32'(q[0].rd));
          chk($sformatf("pc_out[%0d]", g), pc_out, q[0].pc);
          if (!q[0].ill) begin
            chk($sformatf("imm[%0d]", g), imm, q[0].imm);
            chk($sformatf("use_pc[%0d]", g), 32'(use_pc), 32'(q[0].use_pc));
          end
        end
      end
      if (out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic drive(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl,
                       input bit rst);
    in_valid  = iv;
    instr     = ins;
    pc        = $urandom;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(g_dut[0].out_valid), 32'h0);
    chk("rst_illegal", 32'(g_dut[0].illegal_o), 32'h0);
    chk("rst_alu_sel", 32'(g_dut[0].alu_sel), 32'h0);
    chk("rst_imm", g_dut[0].imm, 32'h0);
    chk("rst_pc_out", g_dut[0].pc_out, 32'h0);
    mon_en = 1'b1;

    drive(1'b1, 32'h002081B3, 1'b1, 1'b0, 1'b0);
    chk("add_alu", 32'(g_dut[0].alu_sel), 32'h2);
    chk("add_rs1", 32'(g_dut[0].rs1), 32'd1);
    chk("add_rs2", 32'(g_dut[0].rs2), 32'd2);
    chk("add_rd", 32'(g_dut[0].rd), 32'd3);
    chk("add_use_imm", 32'(g_dut[0].use_imm), 32'h0);
    chk("add_rw", 32'(g_dut[0].reg_write), 32'h1);
    drive(1'b1, 32'h402081B3, 1'b1, 1'b0, 1'b0);
    chk("sub_alu", 32'(g_dut[0].alu_sel), 32'h6);
    drive(1'b1, 32'h40335293, 1'b1, 1'b0, 1'b0);
    chk("srai_alu", 32'(g_dut[0].alu_sel), 32'hB);
    chk("srai_imm", g_dut[0].imm, 32'd3);
    chk("srai_use_imm", 32'(g_dut[0].use_imm), 32'h1);
    drive(1'b1, 32'h123450B7, 1'b1, 1'b0, 1'b0);
    chk("lui_alu", 32'(g_dut[0].alu_sel), 32'hA);
    chk("lui_imm", g_dut[0].imm, 32'h12345000);
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0, 1'b0);
    chk("addi_imm", g_dut[0].imm, 32'hFFFFFFFF);

    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(g_dut[0].in_ready), 32'h0);
      chk("stall_imm", g_dut[0].imm, 32'hFFFFFFFF);
    end
    drive(1'b1, 32'h123450B7, 1'b1, 1'b0, 1'b0);
    chk("resume_alu", 32'(g_dut[0].alu_sel), 32'hA);

    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", 32'(g_dut[0].out_valid), 32'h0);
    chk("flush_illegal", 32'(g_dut[0].illegal_o), 32'h0);

    drive(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    chk("ill_pulse", 32'(g_dut[0].illegal_o), 32'h1);
    chk("ill_rw", 32'(g_dut[0].reg_write), 32'h0);
    chk("ill_alu", 32'(g_dut[0].alu_sel), 32'h2);
    chk("drop_valid", 32'(g_dut[1].out_valid), 32'h0);
    chk("drop_pulse", 32'(g_dut[1].illegal_o), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("ill_pulse_end", 32'(g_dut[0].illegal_o), 32'h0);

    drive(1'b1, 32'h002081B3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    chk("midrst_valid", 32'(g_dut[0].out_valid), 32'h0);
    chk("midrst_illegal", 32'(g_dut[0].illegal_o), 32'h0);
    chk("midrst_alu", 32'(g_dut[0].alu_sel), 32'h0);

    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(9) < 7, rand_instr(), $urandom_range(9) < 7,
            $urandom_range(19) == 0, $urandom_range(99) == 0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
